// File: rtl/muldiv_stall_scheduler.sv
// EX-stage mul/div sequencer: freezes the pipe while the unit runs
// and merges that freeze with hazard-unit stall/flush requests.
module muldiv_stall_scheduler #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       StartE,
  input  logic       IsDivE,
  input  logic [4:0] RdE,
  input  logic       KillE,
  input  logic       HazStallF,
  input  logic       HazStallD,
  input  logic       HazFlushD,
  input  logic       HazFlushE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MdStart,
  output logic       MdBusy,
  output logic       MdDone,
  output logic [4:0] MdRd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       md_rd_q, md_rd_d;
  logic             launch;
  logic             md_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    launch  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (StartE && !KillE) begin
          launch  = 1'b1;
          state_d = S_BUSY;
          cnt_d   = IsDivE ? DIV_CNT : MUL_CNT;
          md_rd_d = RdE;
        end
      end
      S_BUSY: begin
        if (KillE) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by rst_n so a held reset never freezes the pipe.
  always_comb begin
    md_stall = rst_n && !KillE &&
               (launch || (state_q == S_BUSY));
    MdStart  = rst_n && launch;
    MdBusy   = (state_q == S_BUSY);
    MdDone   = (state_q == S_DONE) && !KillE;
    MdRd     = md_rd_q;
    StallF   = HazStallF | md_stall;
    StallD   = HazStallD | md_stall;
    StallE   = md_stall;
    FlushD   = HazFlushD & !md_stall;
    FlushE   = (HazFlushE & !md_stall) | KillE;
    FlushM   = md_stall;
  end

endmodule

// File: tb/tb_muldiv_stall_scheduler.sv
// Scoreboard bench for muldiv_stall_scheduler: per-cycle control
// vectors and retiring MdRd values are queued and checked by a monitor.
module tb_muldiv_stall_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       StartE = 1'b0;
  logic       IsDivE = 1'b0;
  logic [4:0] RdE = '0;
  logic       KillE = 1'b0;
  logic       HazStallF = 1'b0;
  logic       HazStallD = 1'b0;
  logic       HazFlushD = 1'b0;
  logic       HazFlushE = 1'b0;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       MdStart, MdBusy, MdDone;
  logic [4:0] MdRd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  logic [4:0] rd_q[$];

  always #5 clk = ~clk;

  muldiv_stall_scheduler #(
    .MUL_LAT(3),
    .DIV_LAT(32),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .StartE(StartE),
    .IsDivE(IsDivE),
    .RdE(RdE),
    .KillE(KillE),
    .HazStallF(HazStallF),
    .HazStallD(HazStallD),
    .HazFlushD(HazFlushD),
    .HazFlushE(HazFlushE),
    .StallF(StallF),
    .StallD(StallD),
    .StallE(StallE),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .FlushM(FlushM),
    .MdStart(MdStart),
    .MdBusy(MdBusy),
    .MdDone(MdDone),
    .MdRd(MdRd)
  );

  // exp bits: StallF StallD StallE FlushD FlushE FlushM MdStart MdBusy MdDone
  // hz bits: HazStallF HazStallD HazFlushD HazFlushE
  task automatic step(input logic rst, input logic [3:0] hz,
                      input logic st, input logic dv,
                      input logic [4:0] rd, input logic kl,
                      input logic [8:0] exp, input logic [4:0] erd);
    @(posedge clk);
    #1;
    rst_n     = rst;
    HazStallF = hz[3];
    HazStallD = hz[2];
    HazFlushD = hz[1];
    HazFlushE = hz[0];
    StartE    = st;
    IsDivE    = dv;
    RdE       = rd;
    KillE     = kl;
    exp_q.push_back(exp);
    if (exp[0]) rd_q.push_back(erd);
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] e;
    logic [4:0] r;
    act = {StallF, StallD, StallE, FlushD, FlushE,
           FlushM, MdStart, MdBusy, MdDone};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL ctrl cyc=%0d got=%b want=%b", cyc, act, e);
      end
    end
    if (MdDone === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done cyc=%0d got=1 want=0", cyc);
      end else begin
        r = rd_q.pop_front();
        if (MdRd !== r) begin
          failures++;
          $display("FAIL md_rd cyc=%0d got=%0d want=%0d", cyc, MdRd, r);
        end
      end
    end
    if (!rst_n) begin
      checks++;
      if (MdRd !== 5'd0) begin
        failures++;
        $display("FAIL rst_rd cyc=%0d got=%0d want=0", cyc, MdRd);
      end
    end
    cyc++;
  end

  initial begin
    // reset held with StartE=1: no freeze, hazards pass through
    step(0, 4'b0000, 1, 0, 5, 0, 9'b000000000, 0);
    step(0, 4'b1010, 1, 0, 5, 0, 9'b100100000, 0);
    // MUL, launch on first edge after release; RdE/IsDivE change ignored
    step(1, 4'b0000, 1, 0, 5, 0, 9'b111001100, 0);
    step(1, 4'b0000, 0, 1, 9, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 1, 9, 0, 9'b111001010, 0);
    step(1, 4'b0000, 1, 0, 9, 0, 9'b000000001, 5);
    step(1, 4'b0000, 0, 0, 0, 0, 9'b000000000, 0);
    // DIV: 32 stall cycles, done at 32
    step(1, 4'b0000, 1, 1, 12, 0, 9'b111001100, 0);
    for (int i = 1; i < 32; i++)
      step(1, 4'b0000, 0, 0, 20, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 0, 0, 0, 9'b000000001, 12);
    // back-to-back MUL at LAT+1 with hazard requests overlapping
    step(1, 4'b0101, 1, 0, 3, 0, 9'b111001100, 0);
    step(1, 4'b0101, 0, 0, 3, 0, 9'b111001010, 0);
    step(1, 4'b0101, 0, 0, 3, 0, 9'b111001010, 0);
    step(1, 4'b0101, 0, 0, 3, 0, 9'b010010001, 3);
    step(1, 4'b0101, 0, 0, 3, 0, 9'b010010000, 0);
    // DIV killed in cycle 10: no MdDone afterwards
    step(1, 4'b0000, 1, 1, 7, 0, 9'b111001100, 0);
    for (int i = 1; i < 10; i++)
      step(1, 4'b0000, 0, 0, 7, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 0, 7, 1, 9'b000010010, 0);
    for (int i = 0; i < 35; i++)
      step(1, 4'b0000, 0, 0, 7, 0, 9'b000000000, 0);
    // kill in IDLE blocks the launch
    step(1, 4'b0000, 1, 0, 8, 1, 9'b000010000, 0);
    step(1, 4'b0000, 0, 0, 8, 0, 9'b000000000, 0);
    // kill in DONE suppresses MdDone; StartE there ignored
    step(1, 4'b0000, 1, 0, 4, 0, 9'b111001100, 0);
    step(1, 4'b0000, 0, 0, 4, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 0, 4, 0, 9'b111001010, 0);
    step(1, 4'b0000, 1, 0, 4, 1, 9'b000010000, 0);
    step(1, 4'b0000, 0, 0, 4, 0, 9'b000000000, 0);
    // async reset in cycle 2 of a MUL
    step(1, 4'b0000, 1, 0, 6, 0, 9'b111001100, 0);
    step(1, 4'b0000, 0, 0, 6, 0, 9'b111001010, 0);
    step(0, 4'b0000, 0, 0, 6, 0, 9'b000000000, 0);
    step(1, 4'b0000, 0, 0, 6, 0, 9'b000000000, 0);
    step(1, 4'b0000, 0, 0, 6, 0, 9'b000000000, 0);
    // fresh MUL after reset recovery
    step(1, 4'b0000, 1, 0, 11, 0, 9'b111001100, 0);
    step(1, 4'b0000, 0, 0, 11, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 0, 11, 0, 9'b111001010, 0);
    step(1, 4'b0000, 0, 0, 11, 0, 9'b000000001, 11);
    step(1, 4'b0000, 0, 0, 0, 0, 9'b000000000, 0);
    @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d want=0/0",
               rd_q.size(), exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
